serial_subtractor_ctrl: RTL and testbench

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a-b subtractor: one shared full-subtractor cell, LSB first.
// Optional zero flag enabled by defining SERSUB_ZERO_FLAG_EN.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERSUB_ZERO_FLAG_EN
    logic             zacc_q, zacc_d;
    logic             zero_q, zero_d;
`endif

    // Half subtractor as a 4:1 mux on {x,y}; returns {diff, borrow}.
    function automatic logic [1:0] hsub(input logic x, input logic y);
        logic [1:0] r;
        case ({x, y})
            2'b00:   r = 2'b00;
            2'b01:   r = 2'b11;
            2'b10:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    logic ai, bi, d1, b1, b2, cell_d, cell_bout;

    always_comb begin
        ai        = a_q[cnt_q];
        bi        = b_q[cnt_q];
        {d1, b1}  = hsub(ai, bi);
        {cell_d, b2} = hsub(d1, brw_q);
        cell_bout = b1 | b2;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
        zacc_d   = zacc_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
                    zacc_d  = 1'b1;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sr_d  = {cell_d, sr_q[WIDTH-1:1]};
                brw_d = cell_bout;
                cnt_d = cnt_q + CW'(1);
`ifdef SERSUB_ZERO_FLAG_EN
                zacc_d = zacc_q & ~cell_d;
`endif
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    diff_d   = {cell_d, sr_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
`ifdef SERSUB_ZERO_FLAG_EN
                    zero_d   = zacc_q & ~cell_d;
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
            zacc_q   <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERSUB_ZERO_FLAG_EN
            zacc_q   <= zacc_d;
            zero_q   <= zero_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int tests = 0;
    int failed = 0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERSUB_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; returns edges elapsed since the accept edge.
    task automatic wait_done(output int lat, output bit early_change);
        logic [W-1:0] d0;
        logic         b0;
        d0 = diff;
        b0 = borrow;
        lat = 0;
        early_change = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done && (diff !== d0 || borrow !== b0)) early_change = 1;
        end
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input string nm);
        int lat;
        bit early;
        logic [W-1:0] exp_d;
        logic         exp_b;
        exp_d = av - bv;
        exp_b = (av < bv);
        start = 1'b1;
        a = av;
        b = bv;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL %s accept: busy=%b want 1", nm, busy);
        end
        wait_done(lat, early);
        tests++;
        if (lat != W) begin
            failed++;
            $display("FAIL %s latency: %0d want %0d", nm, lat, W);
        end
        tests++;
        if (early) begin
            failed++;
            $display("FAIL %s outputs moved before done", nm);
        end
        tests++;
        if (diff !== exp_d || borrow !== exp_b) begin
            failed++;
            $display("FAIL %s result: diff=%h borrow=%b want %h %b",
                     nm, diff, borrow, exp_d, exp_b);
        end
`ifdef SERSUB_ZERO_FLAG_EN
        tests++;
        if (zero !== (exp_d == '0)) begin
            failed++;
            $display("FAIL %s zero: %b want %b", nm, zero, exp_d == '0);
        end
`endif
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_d) begin
            failed++;
            $display("FAIL %s after done: done=%b busy=%b diff=%h",
                     nm, done, busy, diff);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        step();
        step();
        tests++;
        if (busy !== 0 || done !== 0 || diff !== '0 || borrow !== 0) begin
            failed++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b",
                     busy, done, diff, borrow);
        end
`ifdef SERSUB_ZERO_FLAG_EN
        tests++;
        if (zero !== 1'b0) begin
            failed++;
            $display("FAIL reset zero: %b want 0", zero);
        end
`endif
        rst = 1'b0;
        do_op(8'h05, 8'h03, "post_reset_05_03");
    endtask

    task automatic test_directed();
        do_op(8'h03, 8'h05, "03_05");
        do_op(8'h00, 8'h01, "00_01");
        do_op(8'h5A, 8'h5A, "5A_5A");
        do_op(8'hFF, 8'hFF, "FF_FF");
        do_op(8'h00, 8'hFF, "00_FF");
    endtask

    task automatic test_ignore_start();
        int lat;
        bit early;
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        wait_done(lat, early);
        lat += 2;
        tests++;
        if (lat != W || diff !== 8'h0F || borrow !== 1'b0) begin
            failed++;
            $display("FAIL ignore_start: lat=%0d diff=%h borrow=%b want %0d 0f 0",
                     lat, diff, borrow, W);
        end
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL back_to_back idle: busy=%b done=%b", busy, done);
        end
        step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL back_to_back accept: busy=%b want 1", busy);
        end
        wait_done(lat, early);
        tests++;
        if (lat != W || diff !== 8'hFF || borrow !== 1'b0) begin
            failed++;
            $display("FAIL back_to_back result: lat=%0d diff=%h borrow=%b",
                     lat, diff, borrow);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        start = 1'b1;
        a = 8'h33;
        b = 8'h11;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        tests++;
        if (busy !== 0 || done !== 0 || diff !== '0 || borrow !== 0) begin
            failed++;
            $display("FAIL mid_reset: busy=%b done=%b diff=%h borrow=%b",
                     busy, done, diff, borrow);
        end
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            step();
            if (done || busy) saw_done = 1;
        end
        tests++;
        if (saw_done) begin
            failed++;
            $display("FAIL mid_reset: aborted op still active/done");
        end
        do_op(8'h80, 8'h7F, "80_7F");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] av, bv;
            av = W'($urandom);
            bv = (i % 5 == 0) ? av : W'($urandom);
            do_op(av, bv, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
